// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state and error encodings for the instruction-memory loader
package program_loader_pkg;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE    = 3'd0;
    localparam loader_state_t ST_LEN_LO  = 3'd1;
    localparam loader_state_t ST_LEN_HI  = 3'd2;
    localparam loader_state_t ST_PAYLOAD = 3'd3;
    localparam loader_state_t ST_CHECK   = 3'd4;
    localparam loader_state_t ST_DONE    = 3'd5;
    localparam loader_state_t ST_ERROR   = 3'd6;

    typedef logic [1:0] loader_err_t;

    localparam loader_err_t ERR_NONE    = 2'd0;
    localparam loader_err_t ERR_LEN     = 2'd1;
    localparam loader_err_t ERR_CSUM    = 2'd2;
    localparam loader_err_t ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - packs payload bytes into little-endian words and keeps their running XOR
module program_loader_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic [31:0] word_o,
    output logic [7:0]  xor_o,
    output logic        word_valid_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;
    logic        valid_q, valid_d;

    // Bytes enter at the top so the first byte of a word ends up in bits [7:0].
    always_comb begin
        lane_d  = lane_q;
        word_d  = word_q;
        xor_d   = xor_q;
        valid_d = 1'b0;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
            xor_d  = '0;
        end else if (byte_en_i) begin
            word_d  = {byte_i, word_q[31:8]};
            lane_d  = lane_q + 2'd1;
            xor_d   = xor_q ^ byte_i;
            valid_d = (lane_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q  <= '0;
            word_q  <= '0;
            xor_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
            valid_q <= valid_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_o       = word_q;
    assign xor_o        = xor_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes instruction memory and gates the CPU reset
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_DEPTH      = 4096,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_addr_out,
    output logic              inst_we_out,
    output logic              cpu_rst_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [1:0]        err_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    loader_state_t     state_q, state_d;
    loader_err_t       err_q, err_d;
    logic [15:0]       len_q, len_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [1:0]  lane;
    logic [31:0] word;
    logic [7:0]  xsum;
    logic        word_valid;
    logic        accept;
    logic        byte_en;
    logic        timing;
    logic        last_word;
    logic [15:0] len_full;

    // CHECK withholds ready during the final word's strobe so the two never share a cycle.
    assign byte_ready_out = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                            (state_q == ST_PAYLOAD) ||
                            ((state_q == ST_CHECK) && !word_valid);
    assign accept    = byte_valid_in && byte_ready_out && !start_in;
    assign byte_en   = accept && (state_q == ST_PAYLOAD);
    assign timing    = (state_q == ST_LEN_HI) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign last_word = ((len_q - 16'd1) == 16'(idx_q));
    assign len_full  = {byte_in, len_q[7:0]};

    program_loader_word_assembler u_asm (
        .clk_i        (clk_in),
        .rst_ni       (rst_n_in),
        .clear_i      (start_in),
        .byte_en_i    (byte_en),
        .byte_i       (byte_in),
        .lane_o       (lane),
        .word_o       (word),
        .xor_o        (xsum),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        len_d   = len_q;
        idx_d   = word_valid ? idx_q + ADDR_W'(1) : idx_q;
        timer_d = (timing && !accept) ? timer_q + TW'(1) : '0;
        if (start_in) begin
            state_d = ST_LEN_LO;
            err_d   = ERR_NONE;
            len_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LEN_LO: if (accept) begin
                    len_d[7:0] = byte_in;
                    state_d    = ST_LEN_HI;
                end
                ST_LEN_HI: if (accept) begin
                    len_d = len_full;
                    if ((len_full == 16'd0) || ({1'b0, len_full} > 17'(MEM_DEPTH))) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (accept && (lane == 2'd3) && last_word) state_d = ST_CHECK;
                ST_CHECK: if (accept) begin
                    if (byte_in == xsum) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: ;
                default: state_d = ST_IDLE;
            endcase
            if (timing && !accept && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                state_d = ST_ERROR;
                err_d   = ERR_TIMEOUT;
            end
        end
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            len_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
        end
    end

    assign inst_out      = word;
    assign inst_addr_out = idx_q;
    assign inst_we_out   = word_valid;
    assign cpu_rst_out   = (state_q != ST_DONE);
    assign done_out      = (state_q == ST_DONE);
    assign busy_out      = (state_q == ST_LEN_LO) || timing;
    assign err_out       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed and randomized frames checked against a frame-level reference model
module tb_program_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bdata = 8'h00;
    logic        bvalid = 1'b0;
    logic        byte_ready_out;
    logic [31:0] inst_out;
    logic [11:0] inst_addr_out;
    logic        inst_we_out;
    logic        cpu_rst_out;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  err_out;

    int cmp = 0;
    int fails = 0;

    logic [11:0] got_addr[$];
    logic [31:0] got_data[$];

    always #5 clk = ~clk;

    program_loader #(
        .MEM_DEPTH      (4096),
        .ADDR_W         (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .byte_in        (bdata),
        .byte_valid_in  (bvalid),
        .byte_ready_out (byte_ready_out),
        .inst_out       (inst_out),
        .inst_addr_out  (inst_addr_out),
        .inst_we_out    (inst_we_out),
        .cpu_rst_out    (cpu_rst_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out)
    );

    // Instruction-memory write capture
    always @(negedge clk) begin
        if (inst_we_out) begin
            got_addr.push_back(inst_addr_out);
            got_data.push_back(inst_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic with_byte);
        start  = 1'b1;
        bvalid = with_byte;
        bdata  = 8'hA5;
        @(negedge clk);
        start  = 1'b0;
        bvalid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        bdata  = b;
        bvalid = 1'b1;
        while (!byte_ready_out && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready_out) chk("byte_ready_wait", {31'd0, byte_ready_out}, 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int max_gap);
        foreach (fr[i]) begin
            tick($urandom_range(0, max_gap));
            send_byte(fr[i]);
        end
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] p[$]);
        logic [7:0] x;
        x = 8'h00;
        foreach (p[i]) x = x ^ p[i];
        return x;
    endfunction

    task automatic run_frame(input logic [7:0] p[$], input logic [7:0] csb, input int max_gap);
        logic [7:0]  fr[$];
        logic [15:0] n;
        n = 16'(p.size() / 4);
        fr = {n[7:0], n[15:8]};
        foreach (p[i]) fr.push_back(p[i]);
        fr.push_back(csb);
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        send_frame(fr, max_gap);
        tick(3);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] p[$], input logic good);
        int n;
        logic [31:0] w;
        n = p.size() / 4;
        chk({tag, "_nwrites"}, got_data.size(), n);
        for (int i = 0; i < n; i++) begin
            w = {p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]};
            chk({tag, "_addr"}, (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hFFFF_FFFF, i);
            chk({tag, "_data"}, (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF, w);
        end
        chk({tag, "_err"}, err_out, good ? 0 : 2);
        chk({tag, "_done"}, done_out, good);
        chk({tag, "_cpu_rst"}, cpu_rst_out, !good);
        chk({tag, "_busy"}, busy_out, 0);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] cs;
        logic       good;
        int         k;
        int         n;

        // Reset state
        tick(2);
        chk("rst_ready", byte_ready_out, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_addr", inst_addr_out, 0);
        chk("rst_we", inst_we_out, 0);
        chk("rst_cpu_rst", cpu_rst_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", err_out, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_ready", byte_ready_out, 0);

        // Two-word program, correct checksum
        p = {8'h93, 8'h85, 8'h15, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
        run_frame(p, xor_of(p), 1);
        check_frame("good2", p, 1'b1);
        chk("good2_word0", (got_data.size() > 0) ? got_data[0] : 32'h0, 32'h0015_8593);
        chk("good2_word1", (got_data.size() > 1) ? got_data[1] : 32'h0, 32'h0000_0513);

        // Same program, wrong checksum
        run_frame(p, 8'h84, 0);
        check_frame("badcs", p, 1'b0);

        // Restart clears the error
        pulse_start(1'b0);
        chk("restart_err", err_out, 0);
        chk("restart_busy", busy_out, 1);
        chk("restart_cpu_rst", cpu_rst_out, 1);

        // Illegal lengths
        got_addr.delete();
        got_data.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        tick(2);
        chk("len0_err", err_out, 1);
        chk("len0_ready", byte_ready_out, 0);
        pulse_start(1'b0);
        send_byte(8'h01);
        send_byte(8'h10);
        tick(2);
        chk("len4097_err", err_out, 1);
        chk("len4097_cpu_rst", cpu_rst_out, 1);
        chk("len_nwrites", got_data.size(), 0);

        // LEN_LO waits indefinitely
        pulse_start(1'b0);
        tick(3 * TO);
        chk("lenlo_err", err_out, 0);
        chk("lenlo_ready", byte_ready_out, 1);

        // Stall mid-word until timeout
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        k = 0;
        while (err_out != 2'd3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_err", err_out, 3);
        chk("timeout_nwrites", got_data.size(), 0);
        chk("timeout_busy", busy_out, 0);

        // Restart after 1.5 words, then a one-word frame
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        send_frame({8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF}, 0);
        pulse_start(1'b1);
        chk("midstart_busy", busy_out, 1);
        p = {8'h37, 8'h01, 8'h00, 8'h80};
        send_frame({8'h01, 8'h00, 8'h37, 8'h01, 8'h00, 8'h80, xor_of(p)}, 1);
        tick(3);
        chk("midstart_nwrites", got_data.size(), 2);
        chk("midstart_first", (got_data.size() > 0) ? got_data[0] : 32'h0, 32'hDDCC_BBAA);
        chk("midstart_addr", (got_addr.size() > 1) ? 32'(got_addr[1]) : 32'hFFFF_FFFF, 0);
        chk("midstart_data", (got_data.size() > 1) ? got_data[1] : 32'h0, 32'h8000_0137);
        chk("midstart_done", done_out, 1);

        // Asynchronous reset during a write strobe
        got_addr.delete();
        got_data.delete();
        pulse_start(1'b0);
        send_frame({8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
        chk("pre_arst_we", inst_we_out, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", inst_we_out, 0);
        chk("arst_inst", inst_out, 0);
        chk("arst_addr", inst_addr_out, 0);
        chk("arst_ready", byte_ready_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_cpu_rst", cpu_rst_out, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bvalid = 1'b1;
        bdata = 8'h55;
        tick(5);
        bvalid = 1'b0;
        chk("post_arst_ready", byte_ready_out, 0);
        chk("post_arst_busy", busy_out, 0);
        chk("post_arst_nwrites", got_data.size(), 1);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 6);
            p.delete();
            for (int i = 0; i < 4 * n; i++) p.push_back(8'($urandom_range(0, 255)));
            good = 1'($urandom_range(0, 1));
            cs = xor_of(p);
            if (!good) cs = cs ^ 8'($urandom_range(1, 255));
            run_frame(p, cs, 2);
            check_frame("rand", p, good);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
